// File: rtl/axi_pkg.sv
// Shared AXI3 read-path types: burst and response codes, field widths, arbiter states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axi_pkg;

    localparam int AXI_SIZE_W  = 3;
    localparam int AXI_BURST_W = 2;
    localparam int AXI_RESP_W  = 2;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2
    } axi_burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } axi_resp_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

endpackage

// File: rtl/axi_rd_arb2_if.sv
// AXI3 read-path bundle (AR + R channels) shared by masters and the slave port.
// Latency: n/a (wires only).
// Backpressure: standard valid/ready on both channels.
interface axi_rd_arb2_if
    import axi_pkg::*;
#(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
);
    logic [ID_W-1:0]        arid;
    logic [ADDR_W-1:0]      araddr;
    logic [LEN_W-1:0]       arlen;
    logic [AXI_SIZE_W-1:0]  arsize;
    logic [AXI_BURST_W-1:0] arburst;
    logic                   arvalid;
    logic                   arready;

    logic [ID_W-1:0]        rid;
    logic [DATA_W-1:0]      rdata;
    logic [AXI_RESP_W-1:0]  rresp;
    logic                   rlast;
    logic                   rvalid;
    logic                   rready;

    // Issues reads: drives AR and R-ready.
    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    // Serves reads: accepts AR and drives R data.
    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; on contention the one not granted last wins.
// Latency: grant is combinational from req/en; pointer updates on the granting edge.
// Backpressure: en low suppresses all grants and freezes the pointer.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);
    // 1 means requester 1 won most recently; reset value makes requester 0 win first
    logic last;

    // sole requester wins outright, contention goes to the one not served last
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
            else              gnt = req;
        end
    end

    // pointer moves only when a grant is actually issued
    always_ff @(posedge clk) begin
        if (reset)      last <= 1'b1;
        else if (|gnt)  last <= gnt[1];
    end
endmodule

// File: rtl/axi_rd_arb2.sv
// Two-master AXI3 read arbiter: one burst outstanding, AR registered, R routed to the owner.
// Latency: grant at T gives s_arvalid at T+1; R path is zero-latency pass-through.
// Backpressure: s_arready holds AR stable; s_rready mirrors the owner's rready; stray beats stall.
module axi_rd_arb2
    import axi_pkg::*;
#(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic          aclk,
    input  logic          reset,
    axi_rd_arb2_if.slave  m0,
    axi_rd_arb2_if.slave  m1,
    axi_rd_arb2_if.master s,
    output logic          owner,
    output logic          busy,
    output logic          err_len,
    output logic          err_id
);
    typedef struct packed {
        logic [ID_W-1:0]        id;
        logic [ADDR_W-1:0]      addr;
        logic [LEN_W-1:0]       len;
        logic [AXI_SIZE_W-1:0]  size;
        logic [AXI_BURST_W-1:0] burst;
    } ar_t;

    arb_state_e       state, state_n;
    ar_t              ar_q, ar_win;
    logic [1:0]       req, gnt;
    logic [LEN_W-1:0] cnt;
    logic             past_len;   // beat with index arlen already seen; later beats go unchecked
    logic             owner_q;
    logic             own_rready;
    logic             beat;

    assign req = {m1.arvalid, m0.arvalid};

    rr_arb2 u_arb (
        .clk   (aclk),
        .reset (reset),
        .req   (req),
        .en    (state == ST_IDLE),
        .gnt   (gnt)
    );

    assign ar_win = gnt[1] ? {m1.arid, m1.araddr, m1.arlen, m1.arsize, m1.arburst}
                           : {m0.arid, m0.araddr, m0.arlen, m0.arsize, m0.arburst};

    assign own_rready = owner_q ? m1.rready : m0.rready;
    assign beat       = (state == ST_DATA) && s.rvalid && own_rready;

    // slave AR always shows the latched request; only s_arvalid qualifies it
    assign {s.arid, s.araddr, s.arlen, s.arsize, s.arburst} = ar_q;

    // R payload fans out to both masters; rvalid alone selects the receiver
    assign m0.rid   = s.rid;
    assign m0.rdata = s.rdata;
    assign m0.rresp = s.rresp;
    assign m0.rlast = s.rlast;
    assign m1.rid   = s.rid;
    assign m1.rdata = s.rdata;
    assign m1.rresp = s.rresp;
    assign m1.rlast = s.rlast;

    assign owner = owner_q;
    assign busy  = (state != ST_IDLE);

    // state register
    always_ff @(posedge aclk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    // next state plus handshake outputs for each phase
    always_comb begin
        state_n    = state;
        m0.arready = gnt[0];
        m1.arready = gnt[1];
        s.arvalid  = 1'b0;
        s.rready   = 1'b0;
        m0.rvalid  = 1'b0;
        m1.rvalid  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|gnt) state_n = ST_ADDR;
            end
            ST_ADDR: begin
                s.arvalid = 1'b1;
                if (s.arready) state_n = ST_DATA;
            end
            ST_DATA: begin
                s.rready  = own_rready;
                m0.rvalid = s.rvalid && !owner_q;
                m1.rvalid = s.rvalid &&  owner_q;
                if (beat && s.rlast) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // request latch, owner, beat counter and registered error pulses
    always_ff @(posedge aclk) begin
        if (reset) begin
            ar_q     <= '0;
            owner_q  <= 1'b0;
            cnt      <= '0;
            past_len <= 1'b0;
            err_len  <= 1'b0;
            err_id   <= 1'b0;
        end else begin
            err_len <= 1'b0;
            err_id  <= 1'b0;
            if (|gnt) begin
                ar_q    <= ar_win;
                owner_q <= gnt[1];
            end
            if (state == ST_ADDR && s.arready) begin
                cnt      <= '0;
                past_len <= 1'b0;
            end
            if (beat) begin
                cnt <= cnt + 1'b1;
                if (cnt == ar_q.len) past_len <= 1'b1;
                err_len <= !past_len && (s.rlast ? (cnt != ar_q.len) : (cnt == ar_q.len));
                err_id  <= (s.rid != ar_q.id);
            end
        end
    end
endmodule

// File: tb/tb_axi_rd_arb2.sv
// Self-checking bench for axi_rd_arb2 with a bench-side slave and a spec-level model.
// Latency: checks AR at T+1, zero-latency R routing, error pulses one cycle after the beat.
// Backpressure: exercises s_arready stalls and random/toggling master rready.
module tb_axi_rd_arb2;
    import axi_pkg::*;

    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 4;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [2:0]        size;
        logic [1:0]        burst;
    } ar_t;

    logic aclk = 1'b0;
    logic reset;
    logic owner, busy, err_len, err_id;

    axi_rd_arb2_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) m0_if ();
    axi_rd_arb2_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) m1_if ();
    axi_rd_arb2_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) s_if ();

    axi_rd_arb2 #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .aclk    (aclk),
        .reset   (reset),
        .m0      (m0_if),
        .m1      (m1_if),
        .s       (s_if),
        .owner   (owner),
        .busy    (busy),
        .err_len (err_len),
        .err_id  (err_id)
    );

    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_bad = 0;
    int last_win = 1;   // model: master granted most recently (1 after reset, so m0 wins first)

    // model arbitration: sole requester wins, contention goes to the one not served last
    function automatic int pick(input logic [1:0] reqs);
        if (reqs == 2'b11) return 1 - last_win;
        return reqs[1] ? 1 : 0;
    endfunction

    // model length check on beat index k (0-based); beats past arlen are never flagged
    function automatic bit len_err(input int k, input int len, input bit last);
        if (k > len) return 1'b0;
        return last ? (k != len) : (k == len);
    endfunction

    function automatic ar_t rand_ar();
        ar_t r;
        r.id    = ID_W'($urandom_range(0, 15));
        r.addr  = $urandom;
        r.len   = LEN_W'($urandom_range(0, 7));
        r.size  = 3'($urandom_range(0, 2));
        r.burst = BURST_INCR;
        return r;
    endfunction

    task automatic drive_ar(input int n, input logic v, input ar_t r);
        if (n == 0) begin
            m0_if.arvalid = v;
            {m0_if.arid, m0_if.araddr, m0_if.arlen, m0_if.arsize, m0_if.arburst} = r;
        end else begin
            m1_if.arvalid = v;
            {m1_if.arid, m1_if.araddr, m1_if.arlen, m1_if.arsize, m1_if.arburst} = r;
        end
    endtask

    // request from the masters in reqs; check grant, AR at T+1, stability while stalled
    task automatic ar_phase(input logic [1:0] reqs, input ar_t r0, input ar_t r1,
                            input int delay, output int w);
        ar_t exp;
        w   = pick(reqs);
        exp = (w == 1) ? r1 : r0;
        drive_ar(0, reqs[0], r0);
        drive_ar(1, reqs[1], r1);
        #1;
        n_cmp++;
        if (m0_if.arready !== (w == 0) || m1_if.arready !== (w == 1)) begin
            n_bad++;
            $display("FAIL grant: arready m1,m0=%b%b required %b%b",
                     m1_if.arready, m0_if.arready, w == 1, w == 0);
        end
        @(posedge aclk);
        #1;
        last_win = w;
        if (w == 0) m0_if.arvalid = 1'b0; else m1_if.arvalid = 1'b0;
        #1;
        n_cmp++;
        if (owner !== w[0] || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL owner_busy: owner=%b busy=%b required owner=%0d busy=1", owner, busy, w);
        end
        for (int i = 0; i <= delay; i++) begin
            n_cmp++;
            if (s_if.arvalid !== 1'b1 || m0_if.arready !== 1'b0 || m1_if.arready !== 1'b0 ||
                {s_if.arid, s_if.araddr, s_if.arlen, s_if.arsize, s_if.arburst} !== exp) begin
                n_bad++;
                $display("FAIL slave_ar cyc%0d: arvalid=%b fields=%h arready=%b%b required 1 %h 00",
                         i, s_if.arvalid,
                         {s_if.arid, s_if.araddr, s_if.arlen, s_if.arsize, s_if.arburst},
                         m1_if.arready, m0_if.arready, exp);
            end
            if (i == delay) s_if.arready = 1'b1;
            @(posedge aclk);
            #1;
        end
        s_if.arready  = 1'b0;
        m0_if.arvalid = 1'b0;
        m1_if.arvalid = 1'b0;
    endtask

    // slave returns nbeats; mode 0 rready high, 1 toggling, 2 random with random rvalid gaps
    task automatic r_phase(input int w, input ar_t exp, input logic [ID_W-1:0] rid,
                           input int nbeats, input bit with_last, input int mode);
        int k = 0;
        int cycles = 0;
        bit pend_len = 1'b0;
        bit pend_id  = 1'b0;
        logic rdy, got_v, oth_v, got_l;
        logic [DATA_W-1:0] d, got_d;
        logic [ID_W-1:0] got_id;
        logic [1:0] rr, got_r;
        while (k < nbeats && cycles < 300) begin
            d  = $urandom;
            rr = 2'($urandom_range(0, 3));
            s_if.rvalid = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_if.rid    = rid;
            s_if.rdata  = d;
            s_if.rresp  = rr;
            s_if.rlast  = with_last && (k == nbeats - 1);
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? cycles[0] : 1'($urandom_range(0, 1));
            if (w == 0) begin
                m0_if.rready = rdy; m1_if.rready = 1'($urandom_range(0, 1));
            end else begin
                m1_if.rready = rdy; m0_if.rready = 1'($urandom_range(0, 1));
            end
            #1;
            if (w == 0) begin
                got_v = m0_if.rvalid; oth_v = m1_if.rvalid; got_d = m0_if.rdata;
                got_id = m0_if.rid; got_l = m0_if.rlast; got_r = m0_if.rresp;
            end else begin
                got_v = m1_if.rvalid; oth_v = m0_if.rvalid; got_d = m1_if.rdata;
                got_id = m1_if.rid; got_l = m1_if.rlast; got_r = m1_if.rresp;
            end
            n_cmp++;
            if (got_v !== s_if.rvalid || oth_v !== 1'b0 || s_if.rready !== rdy ||
                (s_if.rvalid && {got_d, got_id, got_l, got_r} !== {d, rid, s_if.rlast, rr})) begin
                n_bad++;
                $display("FAIL r_route beat%0d: v=%b other_v=%b s_rready=%b data=%h id=%h last=%b resp=%h required v=%b 0 %b %h %h %b %h",
                         k, got_v, oth_v, s_if.rready, got_d, got_id, got_l, got_r,
                         s_if.rvalid, rdy, d, rid, s_if.rlast, rr);
            end
            n_cmp++;
            if (err_len !== pend_len || err_id !== pend_id) begin
                n_bad++;
                $display("FAIL err_pulse beat%0d: err_len=%b err_id=%b required %b %b",
                         k, err_len, err_id, pend_len, pend_id);
            end
            if (s_if.rvalid && rdy) begin
                pend_len = len_err(k, int'(exp.len), s_if.rlast);
                pend_id  = (rid != exp.id);
                k++;
            end else begin
                pend_len = 1'b0;
                pend_id  = 1'b0;
            end
            @(posedge aclk);
            #1;
            cycles++;
        end
        if (k < nbeats) begin
            n_cmp++; n_bad++;
            $display("FAIL r_timeout: beats=%0d required %0d", k, nbeats);
        end
        s_if.rvalid  = 1'b0;
        s_if.rlast   = 1'b0;
        m0_if.rready = 1'b1;
        m1_if.rready = 1'b1;
        #1;
        n_cmp++;
        if (err_len !== pend_len || err_id !== pend_id) begin
            n_bad++;
            $display("FAIL err_final: err_len=%b err_id=%b required %b %b", err_len, err_id, pend_len, pend_id);
        end
        if (with_last) begin
            n_cmp++;
            if (busy !== 1'b0 || s_if.rready !== 1'b0) begin
                n_bad++;
                $display("FAIL burst_end: busy=%b s_rready=%b required 0 0", busy, s_if.rready);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        s_if.rvalid  = 1'b1;
        m0_if.rready = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        reset = 1'b0;
        last_win = 1;
        #1;
        n_cmp++;
        if ({s_if.arvalid, s_if.arid, s_if.araddr, s_if.arlen, s_if.arsize, s_if.arburst} !== '0) begin
            n_bad++;
            $display("FAIL reset_ar: s_ar=%h required 0",
                     {s_if.arvalid, s_if.arid, s_if.araddr, s_if.arlen, s_if.arsize, s_if.arburst});
        end
        n_cmp++;
        if ({m0_if.arready, m1_if.arready, m0_if.rvalid, m1_if.rvalid, s_if.rready} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_hs: arready=%b%b rvalid=%b%b s_rready=%b required all 0",
                     m0_if.arready, m1_if.arready, m0_if.rvalid, m1_if.rvalid, s_if.rready);
        end
        n_cmp++;
        if ({owner, busy, err_len, err_id} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_status: owner=%b busy=%b err_len=%b err_id=%b required 0 0 0 0",
                     owner, busy, err_len, err_id);
        end
        s_if.rvalid = 1'b0;
    endtask

    task automatic test_contention();
        int w;
        for (int i = 0; i < 3; i++) begin
            ar_t a = rand_ar();
            ar_t b = rand_ar();
            ar_phase(2'b11, a, b, 0, w);
            r_phase(w, (w == 1) ? b : a, (w == 1) ? b.id : a.id,
                    int'((w == 1) ? b.len : a.len) + 1, 1'b1, 2);
        end
    endtask

    task automatic test_single();
        int w;
        ar_t a = '{id: 4'd3, addr: 32'h100, len: 4'd3, size: 3'd2, burst: BURST_INCR};
        ar_phase(2'b01, a, rand_ar(), 0, w);
        r_phase(w, a, a.id, 4, 1'b1, 0);
    endtask

    task automatic test_back_pressure();
        int w;
        ar_t a = rand_ar();
        a.len = 4'd5;
        ar_phase(2'b01, a, rand_ar(), 5, w);
        r_phase(w, a, a.id, 6, 1'b1, 1);
    endtask

    task automatic test_len_error();
        int w;
        ar_t a = rand_ar();
        a.len = 4'd1;                           // rlast arrives one beat late
        ar_phase(2'b10, rand_ar(), a, 0, w);
        r_phase(w, a, a.id, 3, 1'b1, 0);
        a.len = 4'd0;                           // single-beat burst, correct
        ar_phase(2'b01, a, rand_ar(), 0, w);
        r_phase(w, a, a.id, 1, 1'b1, 0);
        a.len = 4'd3;                           // rlast two beats early
        ar_phase(2'b01, a, rand_ar(), 0, w);
        r_phase(w, a, a.id, 2, 1'b1, 2);
    endtask

    task automatic test_id_error();
        int w;
        ar_t a = rand_ar();
        a.id  = 4'd5;
        a.len = 4'd2;
        ar_phase(2'b01, a, rand_ar(), 1, w);
        r_phase(w, a, 4'd6, 3, 1'b1, 0);
    endtask

    task automatic test_reset_mid_data();
        int w;
        ar_t a = rand_ar();
        a.len = 4'd7;
        ar_phase(2'b10, rand_ar(), a, 0, w);
        r_phase(w, a, a.id, 2, 1'b0, 0);
        s_if.rvalid = 1'b1;
        reset = 1'b1;
        @(posedge aclk);
        #1;
        reset = 1'b0;
        last_win = 1;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || s_if.rready !== 1'b0 || owner !== 1'b0 ||
            m0_if.rvalid !== 1'b0 || m1_if.rvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset: busy=%b s_rready=%b owner=%b rvalid=%b%b required 0 0 0 00",
                     busy, s_if.rready, owner, m1_if.rvalid, m0_if.rvalid);
        end
        s_if.rvalid = 1'b0;
        a = rand_ar();
        ar_phase(2'b11, a, rand_ar(), 0, w);
        r_phase(w, a, a.id, int'(a.len) + 1, 1'b1, 2);
    endtask

    task automatic test_random();
        int w, nb;
        logic [1:0] reqs;
        logic [ID_W-1:0] rid;
        ar_t a, b, e;
        for (int i = 0; i < 12; i++) begin
            reqs = 2'($urandom_range(1, 3));
            a = rand_ar();
            b = rand_ar();
            ar_phase(reqs, a, b, $urandom_range(0, 3), w);
            e  = (w == 1) ? b : a;
            nb = int'(e.len) + 1;
            if ($urandom_range(0, 3) == 0) nb = nb + 1;
            else if ($urandom_range(0, 3) == 0 && e.len != 0) nb = nb - 1;
            rid = ($urandom_range(0, 3) == 0) ? e.id ^ 4'h1 : e.id;
            r_phase(w, e, rid, nb, 1'b1, 2);
        end
    endtask

    initial begin
        reset = 1'b1;
        m0_if.arvalid = 1'b0; m1_if.arvalid = 1'b0;
        {m0_if.arid, m0_if.araddr, m0_if.arlen, m0_if.arsize, m0_if.arburst} = '0;
        {m1_if.arid, m1_if.araddr, m1_if.arlen, m1_if.arsize, m1_if.arburst} = '0;
        m0_if.rready = 1'b0; m1_if.rready = 1'b0;
        s_if.arready = 1'b0; s_if.rvalid = 1'b0; s_if.rlast = 1'b0;
        s_if.rid = '0; s_if.rdata = '0; s_if.rresp = RESP_OKAY;

        test_reset();
        test_contention();
        test_single();
        test_back_pressure();
        test_len_error();
        test_id_error();
        test_reset_mid_data();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
